// File: rtl/axil_pkg.sv
// Shared AXI-Lite register-slave types: response codes, register map and FSM states.
package axil_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = ADDR_W - 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [ADDR_W-1:0] REG0_OFF = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] REG1_OFF = 32'h0000_0004;
    localparam logic [ADDR_W-1:0] REG2_OFF = 32'h0000_0008;
    localparam logic [ADDR_W-1:0] REG3_OFF = 32'h0000_000C;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wbeat_t;

endpackage

// File: rtl/axil_if.sv
// AXI-Lite bus bundle with master and slave views.
interface axil_if;
    import axil_pkg::*;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axil_reg_bank.sv
// Register storage: NUM_REGS-1 byte-writable registers plus a constant ID register at the top index.
module axil_reg_bank
    import axil_pkg::*;
#(
    parameter int unsigned NUM_REGS = 4,
    parameter logic [31:0] ID_VALUE = 32'hA5A5_0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata_c
);

    localparam int unsigned NUM_RW = NUM_REGS - 1;

    logic [DATA_W-1:0] regs [NUM_RW];

    // Byte-strobed write; the caller filters out-of-range and read-only targets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_RW; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            for (int unsigned i = 0; i < NUM_RW; i++) begin
                if (widx == IDX_W'(i)) begin
                    for (int unsigned b = 0; b < STRB_W; b++) begin
                        if (wstrb[b]) begin
                            regs[i][8*b +: 8] <= wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rdata_c = '0;
        if (ridx == IDX_W'(NUM_REGS - 1)) begin
            rdata_c = ID_VALUE;
        end
        for (int unsigned i = 0; i < NUM_RW; i++) begin
            if (ridx == IDX_W'(i)) begin
                rdata_c = regs[i];
            end
        end
    end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI-Lite register slave: independent write (AW/W/B) and read (AR/R) handshake FSMs over axil_reg_bank.
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int unsigned NUM_REGS = 4,
    parameter logic [31:0] ID_VALUE = 32'hA5A5_0001
) (
    input  logic clk,
    input  logic rst,
    axil_if.slave bus
);

    wstate_t           wstate, wstate_n;
    logic              aw_held, aw_held_n;
    logic              w_held, w_held_n;
    logic [IDX_W-1:0]  aw_idx, aw_idx_n;
    wbeat_t            w_beat, w_beat_n;
    logic [1:0]        bresp_q, bresp_n;
    logic              we;

    rstate_t           rstate, rstate_n;
    logic [DATA_W-1:0] rdata_q, rdata_n;
    logic [1:0]        rresp_q, rresp_n;
    logic [DATA_W-1:0] bank_rdata;

    logic              aw_hs, w_hs;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{bus.awaddr[1:0], bus.araddr[1:0]};

    assign bus.awready = !aw_held && (wstate == W_IDLE);
    assign bus.wready  = !w_held  && (wstate == W_IDLE);
    assign bus.bvalid  = (wstate == W_RESP);
    assign bus.bresp   = bresp_q;
    assign bus.arready = (rstate == R_IDLE);
    assign bus.rvalid  = (rstate == R_DATA);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid  && bus.wready;

    // Write FSM: commit on the edge where the second of AW/W becomes held.
    always_comb begin
        wstate_n  = wstate;
        aw_held_n = aw_held;
        w_held_n  = w_held;
        aw_idx_n  = aw_idx;
        w_beat_n  = w_beat;
        bresp_n   = bresp_q;
        we        = 1'b0;
        case (wstate)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_n = 1'b1;
                    aw_idx_n  = bus.awaddr[ADDR_W-1:2];
                end
                if (w_hs) begin
                    w_held_n = 1'b1;
                    w_beat_n = '{data: bus.wdata, strb: bus.wstrb};
                end
                if (aw_held_n && w_held_n) begin
                    wstate_n = W_RESP;
                    if (aw_idx_n >= IDX_W'(NUM_REGS - 1)) begin
                        bresp_n = RESP_SLVERR;
                    end else begin
                        bresp_n = RESP_OKAY;
                        we      = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    wstate_n  = W_IDLE;
                    aw_held_n = 1'b0;
                    w_held_n  = 1'b0;
                end
            end
        endcase
    end

    // Read FSM: bank read is combinational, so a same-edge write is not yet visible.
    always_comb begin
        rstate_n = rstate;
        rdata_n  = rdata_q;
        rresp_n  = rresp_q;
        case (rstate)
            R_IDLE: begin
                if (bus.arvalid) begin
                    rstate_n = R_DATA;
                    rdata_n  = bank_rdata;
                    rresp_n  = (bus.araddr[ADDR_W-1:2] >= IDX_W'(NUM_REGS)) ? RESP_SLVERR : RESP_OKAY;
                end
            end
            R_DATA: begin
                if (bus.rready) begin
                    rstate_n = R_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate  <= W_IDLE;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_idx  <= '0;
            w_beat  <= '0;
            bresp_q <= RESP_OKAY;
            rstate  <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            wstate  <= wstate_n;
            aw_held <= aw_held_n;
            w_held  <= w_held_n;
            aw_idx  <= aw_idx_n;
            w_beat  <= w_beat_n;
            bresp_q <= bresp_n;
            rstate  <= rstate_n;
            rdata_q <= rdata_n;
            rresp_q <= rresp_n;
        end
    end

    axil_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .widx    (aw_idx_n),
        .wdata   (w_beat_n.data),
        .wstrb   (w_beat_n.strb),
        .ridx    (bus.araddr[ADDR_W-1:2]),
        .rdata_c (bank_rdata)
    );

endmodule

// File: tb/tb_axil_reg_slave.sv
// Self-checking bench for axil_reg_slave: vector table plus hand-written handshake corner cases.
module tb_axil_reg_slave;
    import axil_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axil_if bus ();

    axil_reg_slave #(
        .NUM_REGS (4),
        .ID_VALUE (32'hA5A5_0001)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    typedef struct packed {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    exp_t wsb[$];
    exp_t rsb[$];
    vec_t vecs[16];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic collect_b();
        exp_t e;
        if (wsb.size() == 0) begin
            chk("wsb_empty", 32'd0, 32'd1);
            return;
        end
        e = wsb.pop_front();
        chk("bvalid", 32'(bus.bvalid), 32'd1);
        chk("bresp", 32'(bus.bresp), 32'(e.resp));
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        chk("bvalid_clear", 32'(bus.bvalid), 32'd0);
    endtask

    task automatic collect_r();
        exp_t e;
        if (rsb.size() == 0) begin
            chk("rsb_empty", 32'd0, 32'd1);
            return;
        end
        e = rsb.pop_front();
        chk("rvalid", 32'(bus.rvalid), 32'd1);
        chk("rdata", bus.rdata, e.data);
        chk("rresp", 32'(bus.rresp), 32'(e.resp));
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        chk("rvalid_clear", 32'(bus.rvalid), 32'd0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] er);
        logic aw_f, w_f;
        int   n;
        @(negedge clk);
        bus.awaddr  = a;
        bus.wdata   = d;
        bus.wstrb   = s;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        wsb.push_back('{data: 32'd0, resp: er});
        n = 0;
        while ((bus.awvalid || bus.wvalid) && n < 20) begin
            aw_f = bus.awvalid && bus.awready;
            w_f  = bus.wvalid && bus.wready;
            @(negedge clk);
            if (aw_f) bus.awvalid = 1'b0;
            if (w_f)  bus.wvalid  = 1'b0;
            n++;
        end
        if (bus.awvalid || bus.wvalid) begin
            chk("wr_accept_timeout", 32'd0, 32'd1);
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
        end
        collect_b();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        int n;
        @(negedge clk);
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        rsb.push_back('{data: ed, resp: er});
        n = 0;
        while (!bus.arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.arready) chk("ar_accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        collect_r();
    endtask

    initial begin
        rst         = 1'b1;
        bus.awaddr  = '0; bus.awvalid = 1'b0;
        bus.wdata   = '0; bus.wstrb   = '0; bus.wvalid = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0; bus.arvalid = 1'b0;
        bus.rready  = 1'b0;

        vecs[0]  = '{1'b0, 32'h00, 32'h0,         4'h0, 32'h0000_0000, RESP_OKAY};
        vecs[1]  = '{1'b1, 32'h04, 32'h1234_5678, 4'hF, 32'h0,         RESP_OKAY};
        vecs[2]  = '{1'b0, 32'h04, 32'h0,         4'h0, 32'h1234_5678, RESP_OKAY};
        vecs[3]  = '{1'b1, 32'h08, 32'hFFFF_FFFF, 4'hF, 32'h0,         RESP_OKAY};
        vecs[4]  = '{1'b1, 32'h08, 32'h0000_0000, 4'h5, 32'h0,         RESP_OKAY};
        vecs[5]  = '{1'b0, 32'h08, 32'h0,         4'h0, 32'hFF00_FF00, RESP_OKAY};
        vecs[6]  = '{1'b1, 32'h0C, 32'h0BAD_F00D, 4'hF, 32'h0,         RESP_SLVERR};
        vecs[7]  = '{1'b0, 32'h0C, 32'h0,         4'h0, 32'hA5A5_0001, RESP_OKAY};
        vecs[8]  = '{1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 32'h0,         RESP_SLVERR};
        vecs[9]  = '{1'b0, 32'h40, 32'h0,         4'h0, 32'h0000_0000, RESP_SLVERR};
        vecs[10] = '{1'b1, 32'h05, 32'hDEAD_BEEF, 4'h0, 32'h0,         RESP_OKAY};
        vecs[11] = '{1'b1, 32'h06, 32'hAABB_CCDD, 4'h8, 32'h0,         RESP_OKAY};
        vecs[12] = '{1'b0, 32'h07, 32'h0,         4'h0, 32'hAA34_5678, RESP_OKAY};
        vecs[13] = '{1'b0, 32'h10, 32'h0,         4'h0, 32'h0000_0000, RESP_SLVERR};
        vecs[14] = '{1'b1, 32'h10, 32'h5555_5555, 4'hF, 32'h0,         RESP_SLVERR};
        vecs[15] = '{1'b0, 32'h08, 32'h0,         4'h0, 32'hFF00_FF00, RESP_OKAY};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_resp", 32'({bus.bresp, bus.rresp}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_readies", 32'({bus.awready, bus.wready, bus.arready}), 32'h7);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
            else               do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
        end

        // W three cycles ahead of AW
        @(negedge clk);
        bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        wsb.push_back('{data: 32'd0, resp: RESP_OKAY});
        @(negedge clk);
        bus.wvalid = 1'b0;
        chk("early_w_wready_low", 32'(bus.wready), 32'd0);
        repeat (2) @(negedge clk);
        chk("early_w_no_bvalid", 32'(bus.bvalid), 32'd0);
        chk("early_w_wready_held", 32'(bus.wready), 32'd0);
        bus.awaddr = 32'h00; bus.awvalid = 1'b1;
        chk("early_w_awready", 32'(bus.awready), 32'd1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        collect_b();
        do_read(32'h00, 32'hCAFE_F00D, RESP_OKAY);

        // Back-pressure on both response channels
        @(negedge clk);
        bus.awaddr = 32'h00; bus.wdata = 32'h1111_1111; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = 32'h04; bus.arvalid = 1'b1;
        wsb.push_back('{data: 32'd0, resp: RESP_OKAY});
        rsb.push_back('{data: 32'hAA34_5678, resp: RESP_OKAY});
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("bp_valids", 32'({bus.bvalid, bus.rvalid}), 32'h3);
            chk("bp_readies", 32'({bus.awready, bus.wready, bus.arready}), 32'h0);
            chk("bp_rdata", bus.rdata, rsb[0].data);
            chk("bp_bresp", 32'(bus.bresp), 32'(wsb[0].resp));
            @(negedge clk);
        end
        collect_b();
        collect_r();

        // Same-edge write and read of one register returns the old value
        @(negedge clk);
        bus.awaddr = 32'h00; bus.wdata = 32'h2222_2222; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = 32'h00; bus.arvalid = 1'b1;
        wsb.push_back('{data: 32'd0, resp: RESP_OKAY});
        rsb.push_back('{data: 32'h1111_1111, resp: RESP_OKAY});
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        collect_b();
        collect_r();
        do_read(32'h00, 32'h2222_2222, RESP_OKAY);

        // Reset between AW and W abandons the write
        @(negedge clk);
        bus.awaddr = 32'h00; bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_readies", 32'({bus.awready, bus.wready, bus.arready}), 32'h7);
        chk("mid_rst_bvalid", 32'(bus.bvalid), 32'd0);
        bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("w_alone_no_bvalid", 32'(bus.bvalid), 32'd0);
            @(negedge clk);
        end
        do_read(32'h00, 32'h0, RESP_OKAY);
        do_read(32'h04, 32'h0, RESP_OKAY);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
